// File: rtl/apf_video_rx.sv
// apf_video_rx: receive-side monitor for the APF display video stream.
// Measures line/frame geometry from hs/vs/de, tracks geometry lock, decodes
// the in-band blanking metadata (preset, field, interlace) and keeps sticky
// protocol-error flags.
//
// Ports:
//   clk_vid        pixel clock, rising edge
//   reset_n        asynchronous active-low reset
//   video_rgb      pixel / metadata word {R,G,B}
//   video_hs/vs    single-cycle sync pulses
//   video_de       data enable
//   err_clear      clears the sticky error flags (a same-cycle set wins)
//   active_width, active_height, total_width, total_lines
//                  geometry of the last closed frame (CW-bit, saturating)
//   frame_done     one-cycle pulse when the geometry outputs update
//   locked         last two closed frames had identical geometry
//   preset, field, interlaced   decoded metadata
//   err_sync_width, err_blank_data, err_ragged   sticky error flags
module apf_video_rx #(
  parameter int CW = 12
) (
  input  logic          clk_vid,
  input  logic          reset_n,
  input  logic [23:0]   video_rgb,
  input  logic          video_hs,
  input  logic          video_vs,
  input  logic          video_de,
  input  logic          err_clear,
  output logic [CW-1:0] active_width,
  output logic [CW-1:0] active_height,
  output logic [CW-1:0] total_width,
  output logic [CW-1:0] total_lines,
  output logic          frame_done,
  output logic          locked,
  output logic [2:0]    preset,
  output logic          field,
  output logic          interlaced,
  output logic          err_sync_width,
  output logic          err_blank_data,
  output logic          err_ragged
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] MAX_C  = {CW{1'b1}};

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    if (v == MAX_C) begin
      r = v;
    end else begin
      r = v + ONE_C;
    end
    return r;
  endfunction

  state_t        state_r, state_n_s;
  logic [CW-1:0] h_cnt_r, de_cnt_r;
  logic [CW-1:0] line_cnt_r, act_lines_r, fwidth_r, ltotal_r;
  logic          fwidth_vld_r;
  logic          hs_d_r, vs_d_r;

  logic [CW-1:0] line_cnt_s, act_lines_s, fwidth_s, ltotal_s;
  logic          fwidth_vld_s, ragged_s, geom_eq_s, latch_s;
  logic          ilace_word_s, preset_word_s;
  logic          sync_err_s, blank_err_s;

  // Frame accumulators including the line that an hs in this cycle closes;
  // on a vs cycle these are the values the frame is latched with.
  always_comb begin
    line_cnt_s   = line_cnt_r;
    act_lines_s  = act_lines_r;
    fwidth_s     = fwidth_r;
    fwidth_vld_s = fwidth_vld_r;
    ltotal_s     = ltotal_r;
    ragged_s     = 1'b0;
    if (video_hs) begin
      line_cnt_s = sat_inc(line_cnt_r);
      ltotal_s   = h_cnt_r;
      if (de_cnt_r != ZERO_C) begin
        act_lines_s = sat_inc(act_lines_r);
        if (fwidth_vld_r) begin
          ragged_s = (de_cnt_r != fwidth_r);
        end else begin
          fwidth_s     = de_cnt_r;
          fwidth_vld_s = 1'b1;
        end
      end else begin
        act_lines_s = act_lines_r;
      end
    end else begin
      line_cnt_s = line_cnt_r;
    end
  end

  assign geom_eq_s = (fwidth_s == active_width) && (act_lines_s == active_height) &&
                     (ltotal_s == total_width) && (line_cnt_s == total_lines);

  // Metadata words only count on blanking (de=0) cycles.
  assign ilace_word_s  = !video_de && video_vs && (video_rgb[23:4] == 20'h0_0000) &&
                         !video_rgb[0] && (video_rgb[3] != video_rgb[2]);
  assign preset_word_s = !video_de && video_hs && !video_vs &&
                         (video_rgb[23:16] == 8'h00) && (video_rgb[12:0] == 13'h0000);

  assign sync_err_s  = (video_hs && hs_d_r) || (video_vs && vs_d_r);
  assign blank_err_s = !video_de && (video_rgb[23:16] != 8'h00) && (state_r != SEARCH);

  // Next-state logic: SEARCH only waits for the first vs; later vs pulses latch.
  always_comb begin
    state_n_s = state_r;
    latch_s   = 1'b0;
    case (state_r)
      SEARCH: begin
        if (video_vs) begin
          state_n_s = MEASURE;
        end else begin
          state_n_s = SEARCH;
        end
      end
      MEASURE, LOCKED: begin
        if (video_vs) begin
          latch_s   = 1'b1;
          state_n_s = geom_eq_s ? LOCKED : MEASURE;
        end else begin
          state_n_s = state_r;
        end
      end
      default: begin
        state_n_s = SEARCH;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= SEARCH;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Line and frame counters; hs or vs starts a new line, vs also clears the frame.
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_r      <= ZERO_C;
      de_cnt_r     <= ZERO_C;
      line_cnt_r   <= ZERO_C;
      act_lines_r  <= ZERO_C;
      fwidth_r     <= ZERO_C;
      fwidth_vld_r <= 1'b0;
      ltotal_r     <= ZERO_C;
      hs_d_r       <= 1'b0;
      vs_d_r       <= 1'b0;
    end else begin
      hs_d_r <= video_hs;
      vs_d_r <= video_vs;
      if (video_hs || video_vs) begin
        h_cnt_r  <= ONE_C;
        de_cnt_r <= video_de ? ONE_C : ZERO_C;
      end else begin
        h_cnt_r  <= sat_inc(h_cnt_r);
        de_cnt_r <= video_de ? sat_inc(de_cnt_r) : de_cnt_r;
      end
      if (video_vs) begin
        line_cnt_r   <= ZERO_C;
        act_lines_r  <= ZERO_C;
        fwidth_r     <= ZERO_C;
        fwidth_vld_r <= 1'b0;
        ltotal_r     <= ZERO_C;
      end else begin
        line_cnt_r   <= line_cnt_s;
        act_lines_r  <= act_lines_s;
        fwidth_r     <= fwidth_s;
        fwidth_vld_r <= fwidth_vld_s;
        ltotal_r     <= ltotal_s;
      end
    end
  end

  // Geometry outputs, frame_done and locked.
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      active_width  <= ZERO_C;
      active_height <= ZERO_C;
      total_width   <= ZERO_C;
      total_lines   <= ZERO_C;
      frame_done    <= 1'b0;
      locked        <= 1'b0;
    end else begin
      frame_done <= latch_s;
      locked     <= (state_n_s == LOCKED);
      if (latch_s) begin
        active_width  <= fwidth_s;
        active_height <= act_lines_s;
        total_width   <= ltotal_s;
        total_lines   <= line_cnt_s;
      end else begin
        active_width  <= active_width;
        active_height <= active_height;
        total_width   <= total_width;
        total_lines   <= total_lines;
      end
    end
  end

  // Metadata registers.
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      preset     <= 3'd0;
      field      <= 1'b0;
      interlaced <= 1'b0;
    end else begin
      if (ilace_word_s) begin
        field      <= video_rgb[2];
        interlaced <= video_rgb[1];
      end else begin
        field      <= field;
        interlaced <= interlaced;
      end
      if (preset_word_s) begin
        preset <= video_rgb[15:13];
      end else begin
        preset <= preset;
      end
    end
  end

  // Sticky error flags; a set condition overrides err_clear.
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      err_sync_width <= 1'b0;
      err_blank_data <= 1'b0;
      err_ragged     <= 1'b0;
    end else begin
      err_sync_width <= sync_err_s  | (err_sync_width & ~err_clear);
      err_blank_data <= blank_err_s | (err_blank_data & ~err_clear);
      err_ragged     <= ragged_s    | (err_ragged & ~err_clear);
    end
  end

endmodule

// File: tb/tb_apf_video_rx.sv
// Self-checking bench for apf_video_rx. Frames are described by a few
// parameters (line length, line count, de window, active line range); the
// reference model derives the expected geometry, lock and metadata directly
// from those parameters.
module tb_apf_video_rx;

  logic        clk_vid = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:0] video_rgb = 24'h0;
  logic        video_hs = 1'b0, video_vs = 1'b0, video_de = 1'b0, err_clear = 1'b0;

  logic [11:0] active_width, active_height, total_width, total_lines;
  logic        frame_done, locked, field, interlaced;
  logic [2:0]  preset;
  logic        err_sync_width, err_blank_data, err_ragged;

  logic [3:0]  s_aw, s_ah, s_tw, s_tl;
  logic        s_fd, s_lk, s_fld, s_il, s_es, s_eb, s_er;
  logic [2:0]  s_pre;

  apf_video_rx #(.CW(12)) u_dut (
    .clk_vid(clk_vid), .reset_n(reset_n), .video_rgb(video_rgb),
    .video_hs(video_hs), .video_vs(video_vs), .video_de(video_de), .err_clear(err_clear),
    .active_width(active_width), .active_height(active_height),
    .total_width(total_width), .total_lines(total_lines),
    .frame_done(frame_done), .locked(locked), .preset(preset), .field(field),
    .interlaced(interlaced), .err_sync_width(err_sync_width),
    .err_blank_data(err_blank_data), .err_ragged(err_ragged)
  );

  apf_video_rx #(.CW(4)) u_sat (
    .clk_vid(clk_vid), .reset_n(reset_n), .video_rgb(video_rgb),
    .video_hs(video_hs), .video_vs(video_vs), .video_de(video_de), .err_clear(err_clear),
    .active_width(s_aw), .active_height(s_ah), .total_width(s_tw), .total_lines(s_tl),
    .frame_done(s_fd), .locked(s_lk), .preset(s_pre), .field(s_fld),
    .interlaced(s_il), .err_sync_width(s_es), .err_blank_data(s_eb), .err_ragged(s_er)
  );

  always #5 clk_vid = ~clk_vid;

  typedef struct {
    int L; int n; int ds; int dl; int a0; int a1; bit rag;
  } fp_t;

  int vectors = 0, miscompares = 0;
  int fd_count = 0, exp_fd = 0;
  int exp_aw = 0, exp_ah = 0, exp_tw = 0, exp_tl = 0;
  bit exp_lock = 0, exp_fld = 0, exp_int = 0, exp_er = 0, synced = 0, cur_valid = 0;
  logic [2:0] exp_pre = 3'd0, cur_pre = 3'd0;
  fp_t cur_p;

  function automatic fp_t mk(int L, int n, int ds, int dl, int a0, int a1, bit rag);
    fp_t p;
    p.L = L; p.n = n; p.ds = ds; p.dl = dl; p.a0 = a0; p.a1 = a1; p.rag = rag;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pixel clock: drive at the falling edge, sample just after the rising edge.
  task automatic cyc(input logic h, input logic v, input logic d,
                     input logic [23:0] w, input logic clr);
    @(negedge clk_vid);
    video_hs = h; video_vs = v; video_de = d; video_rgb = w; err_clear = clr;
    @(posedge clk_vid);
    #1;
    if (frame_done) fd_count++;
  endtask

  task automatic model_reset();
    synced = 0; cur_valid = 0; exp_lock = 0; exp_fld = 0; exp_int = 0; exp_er = 0;
    exp_aw = 0; exp_ah = 0; exp_tw = 0; exp_tl = 0; exp_pre = 3'd0;
  endtask

  // Reference behaviour at a vs cycle: close the previously emitted frame.
  task automatic close_frame(input logic [23:0] vsw);
    int aw, ah;
    if (vsw[23:4] == 20'h0 && !vsw[0] && vsw[3] != vsw[2]) begin
      exp_fld = vsw[2]; exp_int = vsw[1];
    end
    if (cur_valid && cur_p.n >= 2) exp_pre = cur_pre;
    if (!synced) begin
      synced = 1;
      chk("fd_first_vs", frame_done, 0);
    end else begin
      ah = (cur_p.dl > 0) ? cur_p.a1 - cur_p.a0 + 1 : 0;
      aw = (cur_p.dl > 0) ? cur_p.dl : 0;
      exp_lock = (aw == exp_aw) && (ah == exp_ah) && (cur_p.L == exp_tw) && (cur_p.n == exp_tl);
      exp_aw = aw; exp_ah = ah; exp_tw = cur_p.L; exp_tl = cur_p.n;
      exp_fd++;
      chk("frame_done", frame_done, 1);
      chk("active_width", active_width, exp_aw);
      chk("active_height", active_height, exp_ah);
      chk("total_width", total_width, exp_tw);
      chk("total_lines", total_lines, exp_tl);
    end
    chk("locked", locked, exp_lock);
    chk("preset", preset, exp_pre);
    chk("field", field, exp_fld);
    chk("interlaced", interlaced, exp_int);
    chk("err_sync_width", err_sync_width, 0);
    chk("err_blank_data", err_blank_data, 0);
    chk("err_ragged", err_ragged, exp_er);
  endtask

  // Emit one frame; its first cycle carries vs+hs and closes the previous frame.
  task automatic run_frame(input fp_t p, input logic [2:0] pre, input logic [23:0] vsw);
    chk("fd_count", fd_count, exp_fd);
    for (int i = 0; i < p.n; i++) begin
      for (int c = 0; c < p.L; c++) begin
        int dl_eff;
        logic d;
        logic [23:0] w;
        dl_eff = (p.rag && i == p.a1) ? p.dl - 1 : p.dl;
        d = (i >= p.a0) && (i <= p.a1) && (c >= p.ds) && (c < p.ds + dl_eff);
        if (d) w = 24'($urandom);
        else if (c == 0 && i == 0) w = vsw;
        else if (c == 0) w = {8'h00, pre, 13'h0000};
        else w = 24'h0;
        cyc(c == 0, (i == 0) && (c == 0), d, w, 1'b0);
        if (i == 0 && c == 0) close_frame(vsw);
      end
    end
    cur_p = p; cur_pre = pre; cur_valid = 1;
    if (p.rag) exp_er = 1;
  endtask

  initial begin
    fp_t s6, s7, rg, sat, rp;
    logic [23:0] vs_words [7];
    vs_words = '{24'h000000, 24'h000004, 24'h000008, 24'h00000A,
                 24'h00000C, 24'h000006, 24'h000003};
    s6  = mk(8, 6, 2, 5, 1, 4, 1'b0);
    s7  = mk(8, 7, 2, 5, 1, 4, 1'b0);
    rg  = mk(8, 6, 2, 5, 1, 3, 1'b1);
    sat = mk(20, 3, 2, 5, 0, 2, 1'b0);
    cur_p = s6;

    // Reset state
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
    chk("rst_active_width", active_width, 0);
    chk("rst_total_lines", total_lines, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err_ragged", err_ragged, 0);
    @(negedge clk_vid);
    reset_n = 1'b1;

    // Steady frames
    run_frame(s6, 3'd0, 24'h0);
    run_frame(s6, 3'd0, 24'h0);
    chk("steady_aw", active_width, 5);
    chk("steady_ah", active_height, 4);
    chk("steady_tw", total_width, 8);
    chk("steady_tl", total_lines, 6);
    chk("steady_lock1", locked, 0);
    run_frame(s6, 3'd0, 24'h0);
    chk("steady_lock2", locked, 1);
    run_frame(s6, 3'd0, 24'h0);

    // Lock loss and re-lock
    run_frame(s7, 3'd0, 24'h0);
    run_frame(s7, 3'd0, 24'h0);
    chk("loss_tl", total_lines, 7);
    chk("loss_locked", locked, 0);
    run_frame(s7, 3'd0, 24'h0);
    chk("relock", locked, 1);

    // Random frames, half of them repeating the previous geometry
    rp = s7;
    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(1, 0) == 0) begin
        rp.L  = $urandom_range(16, 6);
        rp.ds = $urandom_range(rp.L - 2, 1);
        rp.dl = $urandom_range(rp.L - rp.ds, 1);
        rp.n  = $urandom_range(10, 2);
        rp.a0 = $urandom_range(rp.n - 1, 0);
        rp.a1 = $urandom_range(rp.n - 1, rp.a0);
        if ($urandom_range(7, 0) == 0) rp.dl = 0;
      end
      run_frame(rp, 3'($urandom_range(7, 0)), vs_words[$urandom_range(6, 0)]);
    end

    // Metadata
    run_frame(s6, 3'd3, 24'h000004);
    chk("meta_field_odd", field, 1);
    chk("meta_ilace_0", interlaced, 0);
    run_frame(s6, 3'd3, 24'h00000A);
    chk("meta_preset3", preset, 3);
    chk("meta_field_even", field, 0);
    chk("meta_ilace_1", interlaced, 1);
    run_frame(s6, 3'd3, 24'h00000C);
    chk("meta_nochg_field", field, 0);
    chk("meta_nochg_ilace", interlaced, 1);

    // Ragged lines 5,5,4
    run_frame(rg, 3'd3, 24'h0);
    run_frame(s6, 3'd3, 24'h0);
    chk("ragged", err_ragged, 1);

    // Protocol errors
    cyc(1'b1, 1'b0, 1'b0, 24'h000001, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 24'h000001, 1'b0);
    chk("sync_width", err_sync_width, 1);
    cyc(1'b0, 1'b0, 1'b0, 24'h100000, 1'b0);
    chk("blank_data", err_blank_data, 1);
    cyc(1'b0, 1'b0, 1'b0, 24'h000000, 1'b1);
    chk("clear_sync", err_sync_width, 0);
    chk("clear_blank", err_blank_data, 0);
    chk("clear_ragged", err_ragged, 0);
    cyc(1'b1, 1'b0, 1'b0, 24'h000001, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 24'h000001, 1'b1);
    chk("set_wins_sync", err_sync_width, 1);
    cyc(1'b0, 1'b0, 1'b0, 24'h100000, 1'b1);
    chk("set_wins_blank", err_blank_data, 1);

    // Reset mid-line, without a clock edge
    cyc(1'b0, 1'b0, 1'b1, 24'h123456, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 24'h654321, 1'b0);
    @(negedge clk_vid);
    #2 reset_n = 1'b0;
    #0.5;
    chk("midrst_aw", active_width, 0);
    chk("midrst_tl", total_lines, 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_preset", preset, 0);
    chk("midrst_field", field, 0);
    chk("midrst_ilace", interlaced, 0);
    chk("midrst_err_sync", err_sync_width, 0);
    chk("midrst_err_blank", err_blank_data, 0);
    #0.5 reset_n = 1'b1;
    model_reset();

    // Saturation: 20-cycle lines in a 4-bit instance
    run_frame(sat, 3'd0, 24'h0);
    run_frame(sat, 3'd0, 24'h0);
    chk("sat_total_width", s_tw, 15);
    chk("wide_total_width", total_width, 20);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
    chk("fd_count_final", fd_count, exp_fd);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
